seven_segment_scanner: RTL and testbench
========================================

SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4: number of multiplexed display digits, legal range 1..8.
REQ-002 The block SHALL have parameter DIVIDER, default 50000: clock cycles per digit slot (1 kHz per digit at 50 MHz), legal when DIVIDER > GAP.
REQ-003 The block SHALL have parameter GAP, default 500: blanking cycles at the start of each slot (ghosting guard), legal when GAP >= 1.
REQ-004 The block SHALL have parameter LEADING_ZERO_BLANK, default 1: 1 suppresses leading zero digits, 0 shows all digits.
REQ-005 The block SHALL have port clock_pos, input, 1 bit: the single clock, rising edge active.
REQ-006 The block SHALL have port reset_neg, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port enable, input, 1 bit: 1 scans, 0 forces idle.
REQ-008 The block SHALL have port vector_in, input, 4*DIGITS bits: nibble i = digit i, with nibble 0 least significant (rightmost digit).
REQ-009 The block SHALL have port vector_out, output, 4 bits: digit value fed to the downstream Seven_Segment_Translator four_bit_number.
REQ-010 The block SHALL have port digit_select_neg, output, DIGITS bits: active-low digit enables.
REQ-011 The block SHALL have port digit_blank, output, 1 bit: 1 when no digit is lit.
REQ-012 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of each full frame.

Function
REQ-013 The block SHALL be clocked only by clock_pos, and all outputs SHALL be decoded from registered state only (no input-to-output combinational path).
REQ-014 The block SHALL implement states IDLE, BLANK and DRIVE, plus a slot counter count (0..DIVIDER-1), a digit index (0..DIGITS-1) and a snapshot register of 4*DIGITS bits.
REQ-015 While in IDLE with enable=1, the next edge SHALL enter BLANK with count=0, index=0 and snapshot<=vector_in.
REQ-016 Outside IDLE, count SHALL increment every cycle; state SHALL be BLANK while count<GAP and DRIVE while count>=GAP.
REQ-017 At count==DIVIDER-1, count SHALL go to 0 and index SHALL increment, wrapping from DIGITS-1 to 0; on the wrap edge the snapshot SHALL be reloaded from vector_in.
REQ-018 vector_in changes mid-frame SHALL NOT affect the digits displayed until the next frame (no tearing).
REQ-019 vector_out SHALL equal snapshot nibble[index] in BLANK and DRIVE, and 0 in IDLE.
REQ-020 In DRIVE, digit_select_neg[index] SHALL be 0 and all other bits 1, unless the digit is suppressed; in BLANK and IDLE all bits SHALL be 1.
REQ-021 Suppression rule (LEADING_ZERO_BLANK=1): digit i>0 SHALL be suppressed when snapshot nibbles i..DIGITS-1 are all zero; digit 0 SHALL never be suppressed.
REQ-022 digit_blank SHALL equal 1 exactly when all digit_select_neg bits are 1.
REQ-023 At most one digit_select_neg bit SHALL be 0 in any cycle.
REQ-024 frame_done SHALL be 1 for exactly the cycle in which count==DIVIDER-1 and index==DIGITS-1 outside IDLE; otherwise 0.
REQ-025 With enable=0 outside IDLE, the next edge SHALL enter IDLE with count=0 and index=0; re-enabling SHALL always restart at digit 0 with a fresh snapshot.

Reset
REQ-026 While reset_neg=0, the block SHALL immediately, without a clock edge, force state=IDLE, count=0, index=0, snapshot=0, vector_out=0, digit_select_neg=all 1, digit_blank=1 and frame_done=0.
REQ-027 After reset release, the block SHALL leave IDLE only on a clock edge with enable=1.

Verification (DIGITS=4, DIVIDER=8, GAP=2)
REQ-028 Scenario: enable=1, vector_in=16'h1234 -> each slot gives 2 blank cycles then 6 cycles with the select low; digits 0..3 show 4,3,2,1 with selects 1110,1101,1011,0111; frame_done pulses every 32 cycles.
REQ-029 Scenario: vector_in=16'h0070 -> slots 3 and 2 remain 1111 with digit_blank=1; digit 1 shows 7 and digit 0 shows 0. With vector_in=0, only digit 0 lights, showing 0.
REQ-030 Scenario: vector_in changes from 1234 to ABCD during slot 1 -> the rest of that frame shows 3,2,1; the next frame shows D,C,B,A.
REQ-031 Scenario: enable deasserted mid-DRIVE -> the next cycle shows selects 1111, digit_blank=1, vector_out=0; re-enable -> BLANK of digit 0 after one edge.
REQ-032 Scenario: reset_neg pulsed low mid-DRIVE between clock edges -> all outputs take their reset values immediately.
REQ-033 Every scenario SHALL continuously check REQ-022 and REQ-023.

Source files
------------

// File: rtl/seven_segment_scanner_if.sv
// Scanner-side bundle: enable and digit vector in, multiplexed digit drive out.
// The master modport belongs to whoever supplies the digits; the slave modport belongs to the scanner.
interface seven_segment_scanner_if #(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic [4*DIGITS-1:0]   vector_in;
  logic [3:0]            vector_out;
  logic [DIGITS-1:0]     digit_select_neg;
  logic                  digit_blank;
  logic                  frame_done;

  modport master (
    output enable, vector_in,
    input  vector_out, digit_select_neg, digit_blank, frame_done
  );

  modport slave (
    input  enable, vector_in,
    output vector_out, digit_select_neg, digit_blank, frame_done
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// Time-multiplexes a frame-snapshotted digit vector onto active-low digit selects, blanking the start of each slot.
// Outputs are decoded from registers only (one-edge latency from enable); there is no backpressure, and the scan free-runs while enabled.
module seven_segment_scanner #(
  parameter int DIGITS             = 4,
  parameter int DIVIDER            = 50000,
  parameter int GAP                = 500,
  parameter bit LEADING_ZERO_BLANK = 1'b1
) (
  input  logic                  clock_pos,
  input  logic                  reset_neg,
  seven_segment_scanner_if.slave bus
);
  localparam int CNT_W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDER - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    count, count_nxt;
  logic [IDX_W-1:0]    index, index_nxt;
  logic [4*DIGITS-1:0] snapshot, snapshot_nxt;
  logic [DIGITS-1:0]   upper_nz;
  logic [DIGITS-1:0]   suppressed;
  logic                acc_nz;

  always_ff @(posedge clock_pos or negedge reset_neg) begin
    if (!reset_neg) begin
      state    <= IDLE;
      count    <= '0;
      index    <= '0;
      snapshot <= '0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      index    <= index_nxt;
      snapshot <= snapshot_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    index_nxt    = index;
    snapshot_nxt = snapshot;
    if (state == IDLE) begin
      if (bus.enable) begin
        state_nxt    = BLANK;
        count_nxt    = '0;
        index_nxt    = '0;
        snapshot_nxt = bus.vector_in;
      end
    end else if (!bus.enable) begin
      state_nxt = IDLE;
      count_nxt = '0;
      index_nxt = '0;
    end else begin
      if (count == CNT_LAST) begin
        count_nxt = '0;
        if (index == IDX_LAST) begin
          index_nxt    = '0;
          // Only the frame boundary samples new digits, so a frame never tears.
          snapshot_nxt = bus.vector_in;
        end else begin
          index_nxt = index + 1'b1;
        end
      end else begin
        count_nxt = count + 1'b1;
      end
      state_nxt = (count_nxt < CNT_W'(GAP)) ? BLANK : DRIVE;
    end
  end

  // upper_nz[i]: any of nibbles i..DIGITS-1 is non-zero.
  always_comb begin
    acc_nz     = 1'b0;
    upper_nz   = '0;
    suppressed = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc_nz        = acc_nz | (|snapshot[4*i +: 4]);
      upper_nz[i]   = acc_nz;
      suppressed[i] = LEADING_ZERO_BLANK && (i != 0) && !acc_nz;
    end
  end

  always_comb begin
    bus.vector_out       = 4'h0;
    bus.digit_select_neg = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (state != IDLE && index == IDX_W'(i))
        bus.vector_out = snapshot[4*i +: 4];
      if (state == DRIVE && index == IDX_W'(i) && !suppressed[i])
        bus.digit_select_neg[i] = 1'b0;
    end
    bus.digit_blank = &bus.digit_select_neg;
    bus.frame_done  = (state != IDLE) && (count == CNT_LAST) && (index == IDX_LAST);
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for the scanner at DIGITS=4, DIVIDER=8, GAP=2 with a per-cycle expected-output scoreboard.
module tb_seven_segment_scanner;
  typedef struct packed {
    logic [3:0] vo;
    logic [3:0] sel;
    logic       blank;
    logic       fd;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   fails  = 0;
  exp_t sb[$];

  seven_segment_scanner_if #(.DIGITS(4)) bus ();

  seven_segment_scanner #(
    .DIGITS(4), .DIVIDER(8), .GAP(2), .LEADING_ZERO_BLANK(1'b1)
  ) dut (
    .clock_pos(clk),
    .reset_neg(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, expv, $time);
    end
  endtask

  // Select/blank consistency and one-hot-low selects, every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("blank_vs_sel", {3'b0, bus.digit_blank}, {3'b0, (&bus.digit_select_neg)});
      check("sel_onehot", {3'b0, ($countones(~bus.digit_select_neg) <= 1)}, 4'h1);
    end
  end

  // Expected outputs for the first n cycles of a frame displaying v.
  task automatic push_frame(input logic [15:0] v, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      int  d;
      int  c;
      logic lit;
      d = k / 8;
      c = k % 8;
      lit = (c >= 2) && ((d == 0) || ((v >> (4 * d)) != 16'h0));
      e.vo    = v[4*d +: 4];
      e.sel   = lit ? ~(4'b0001 << d) : 4'hF;
      e.blank = !lit;
      e.fd    = (k == 31);
      sb.push_back(e);
    end
  endtask

  task automatic push_idle(input int n);
    exp_t e;
    e.vo = 4'h0; e.sel = 4'hF; e.blank = 1'b1; e.fd = 1'b0;
    for (int k = 0; k < n; k++) sb.push_back(e);
  endtask

  task automatic run(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (sb.size() == 0) begin
        check("sb_underflow", 4'h1, 4'h0);
      end else begin
        e = sb.pop_front();
        check("vector_out", bus.vector_out, e.vo);
        check("digit_select_neg", bus.digit_select_neg, e.sel);
        check("digit_blank", {3'b0, bus.digit_blank}, {3'b0, e.blank});
        check("frame_done", {3'b0, bus.frame_done}, {3'b0, e.fd});
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vector_out"}, bus.vector_out, 4'h0);
    check({tag, "_sel"}, bus.digit_select_neg, 4'hF);
    check({tag, "_blank"}, {3'b0, bus.digit_blank}, 4'h1);
    check({tag, "_frame_done"}, {3'b0, bus.frame_done}, 4'h0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.enable    = 1'b0;
    bus.vector_in = 16'h0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_idle(2);
    run(2);

    // Plain scan, two frames.
    bus.enable    = 1'b1;
    bus.vector_in = 16'h1234;
    push_frame(16'h1234, 32);
    run(32);
    push_frame(16'h1234, 32);
    run(32);

    // Leading-zero suppression.
    bus.vector_in = 16'h0070;
    push_frame(16'h0070, 32);
    run(32);
    bus.vector_in = 16'h0000;
    push_frame(16'h0000, 32);
    run(32);

    // Mid-frame change must wait for the next frame.
    bus.vector_in = 16'h1234;
    push_frame(16'h1234, 32);
    run(11);
    bus.vector_in = 16'hABCD;
    run(21);
    push_frame(16'hABCD, 32);
    run(32);

    // Disable during DRIVE, then re-enable with fresh digits.
    push_frame(16'hABCD, 5);
    run(5);
    bus.enable = 1'b0;
    push_idle(3);
    run(3);
    bus.vector_in = 16'h5678;
    bus.enable    = 1'b1;
    push_frame(16'h5678, 32);
    run(32);

    // Asynchronous reset between edges while a digit is lit.
    push_frame(16'h5678, 4);
    run(4);
    check("lit_before_reset", bus.digit_select_neg, 4'hE);
    check("sb_empty", 4'(sb.size()), 4'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    bus.enable = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_held");
    rst_n = 1'b1;
    push_idle(2);
    run(2);
    check("sb_empty_end", 4'(sb.size()), 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
